// File: rtl/cpu_types_pkg.sv
// Shared types and register-match helpers for the pipeline hazard controller.
package cpu_types_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    HALT  = 2'd2
  } hzstate_t;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwdsel_t;

  // $0 is hardwired, so a producer targeting it never creates a dependency.
  function automatic logic id_reads(input logic [REG_W-1:0] dest,
                                    input logic [REG_W-1:0] rs,
                                    input logic [REG_W-1:0] rt,
                                    input logic             use_rt);
    return (dest != '0) && ((dest == rs) || (use_rt && (dest == rt)));
  endfunction

  function automatic logic fwd_match(input logic             regen,
                                     input logic [REG_W-1:0] dest,
                                     input logic [REG_W-1:0] src);
    return regen && (dest != '0) && (dest == src);
  endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Operand forwarding select for the EX stage; the younger EX/MEM result wins over MEM/WB.
module hazard_fwd_unit
  import cpu_types_pkg::*;
(
  input  logic [REG_W-1:0] rsel1,
  input  logic [REG_W-1:0] rsel2,
  input  logic [REG_W-1:0] exmem_wsel,
  input  logic             exmem_regen,
  input  logic [REG_W-1:0] memwb_wsel,
  input  logic             memwb_regen,
  output fwdsel_t          fwd_a,
  output fwdsel_t          fwd_b
);

  always_comb begin
    fwd_a = FWD_RF;
    if (fwd_match(exmem_regen, exmem_wsel, rsel1)) begin
      fwd_a = FWD_EXMEM;
    end else if (fwd_match(memwb_regen, memwb_wsel, rsel1)) begin
      fwd_a = FWD_MEMWB;
    end
  end

  always_comb begin
    fwd_b = FWD_RF;
    if (fwd_match(exmem_regen, exmem_wsel, rsel2)) begin
      fwd_b = FWD_EXMEM;
    end else if (fwd_match(memwb_regen, memwb_wsel, rsel2)) begin
      fwd_b = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/halt control for the IF/ID, ID/EX, EX/MEM and MEM/WB latches plus perf counters.
// Define FORWARD_UNIT_EN to add EX operand forwarding; then only load-use hazards stall.
module pipeline_hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             ifid_usert,
  input  logic [REG_W-1:0] idex_wsel_l,
  input  logic             idex_regen_l,
  input  logic             idex_dmemREN_l,
  input  logic [REG_W-1:0] idex_rsel1_l,
  input  logic [REG_W-1:0] idex_rsel2_l,
  input  logic [REG_W-1:0] exmem_wsel,
  input  logic             exmem_regen,
  input  logic             exmem_dmemREN,
  input  logic             exmem_dmemWEN,
  input  logic [REG_W-1:0] memwb_wsel,
  input  logic             memwb_regen,
  input  logic             memwb_hlt,
  input  logic             br_taken,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_sRST,
  output logic             idex_sRST,
  output logic             exmem_sRST,
  output logic             memwb_sRST,
  output logic [1:0]       fwdA,
  output logic [1:0]       fwdB,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hzstate_t state, state_next;
  logic     run_q;
  logic     mreq;
  logic     reads_idex;
  logic     load_use;
  logic     haz;
  logic     stall_inc;
  logic     flush_inc;

  assign mreq       = exmem_dmemREN | exmem_dmemWEN;
  assign reads_idex = id_reads(idex_wsel_l, ifid_rs, ifid_rt, ifid_usert);
  assign load_use   = idex_dmemREN_l & idex_regen_l & reads_idex;

`ifdef FORWARD_UNIT_EN
  fwdsel_t fwd_a, fwd_b;

  hazard_fwd_unit u_fwd (
    .rsel1       (idex_rsel1_l),
    .rsel2       (idex_rsel2_l),
    .exmem_wsel  (exmem_wsel),
    .exmem_regen (exmem_regen),
    .memwb_wsel  (memwb_wsel),
    .memwb_regen (memwb_regen),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b)
  );

  assign haz  = load_use;
  assign fwdA = run_q ? fwd_a : FWD_RF;
  assign fwdB = run_q ? fwd_b : FWD_RF;
`else
  // Without forwarding, ID must wait until any in-flight producer reaches WB.
  logic reads_exmem;
  logic unused_fwd_inputs;

  assign reads_exmem       = id_reads(exmem_wsel, ifid_rs, ifid_rt, ifid_usert);
  assign haz               = load_use | (idex_regen_l & reads_idex) | (exmem_regen & reads_exmem);
  assign fwdA              = FWD_RF;
  assign fwdB              = FWD_RF;
  assign unused_fwd_inputs = ^{idex_rsel1_l, idex_rsel2_l, memwb_wsel, memwb_regen};
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= RUN;
      run_q <= 1'b0;
    end else begin
      state <= state_next;
      run_q <= 1'b1;
    end
  end

  // Priority: halt, dcache miss, redirect, data hazard, icache miss, normal flow.
  always_comb begin
    state_next = state;
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    idex_en    = 1'b0;
    exmem_en   = 1'b0;
    memwb_en   = 1'b0;
    ifid_sRST  = 1'b0;
    idex_sRST  = 1'b0;
    exmem_sRST = 1'b0;
    memwb_sRST = 1'b0;
    halt       = 1'b0;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;

    if (run_q) begin
      if (state == HALT) begin
        halt = 1'b1;
      end else if (mreq && !dhit) begin
        memwb_sRST = 1'b1;
        stall_inc  = 1'b1;
      end else if (br_taken) begin
        pc_en      = 1'b1;
        ifid_sRST  = 1'b1;
        idex_sRST  = 1'b1;
        exmem_sRST = 1'b1;
        memwb_en   = 1'b1;
        flush_inc  = 1'b1;
      end else if (haz) begin
        idex_sRST  = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        stall_inc  = 1'b1;
      end else if (!ihit) begin
        ifid_sRST  = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        stall_inc  = 1'b1;
      end else begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
      end

      case (state)
        RUN:     if (mreq && !dhit) state_next = DWAIT;
        DWAIT:   if (dhit) state_next = RUN;
        HALT:    state_next = HALT;
        default: state_next = RUN;
      endcase

      // The halting instruction must actually retire, so a frozen MEM/WB defers it.
      if (memwb_hlt && memwb_en) state_next = HALT;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic
// against a rule-level reference model. Expectations follow FORWARD_UNIT_EN when defined.
module tb_pipeline_hazard_ctrl;

  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;
`ifdef FORWARD_UNIT_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct packed {
    logic       ihit;
    logic       dhit;
    logic [4:0] ifid_rs;
    logic [4:0] ifid_rt;
    logic       ifid_usert;
    logic [4:0] idex_wsel_l;
    logic       idex_regen_l;
    logic       idex_dmemREN_l;
    logic [4:0] idex_rsel1_l;
    logic [4:0] idex_rsel2_l;
    logic [4:0] exmem_wsel;
    logic       exmem_regen;
    logic       exmem_dmemREN;
    logic       exmem_dmemWEN;
    logic [4:0] memwb_wsel;
    logic       memwb_regen;
    logic       memwb_hlt;
    logic       br_taken;
  } stim_t;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  stim_t         s;
  logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic          ifid_sRST, idex_sRST, exmem_sRST, memwb_sRST;
  logic [1:0]    fwdA, fwdB;
  logic          halt;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  bit m_run = 1'b0;
  bit m_halted = 1'b0;
  int m_stall = 0;
  int m_flush = 0;

  always #5 CLK = ~CLK;

  pipeline_hazard_ctrl #(.CNT_W(CW)) dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .ihit           (s.ihit),
    .dhit           (s.dhit),
    .ifid_rs        (s.ifid_rs),
    .ifid_rt        (s.ifid_rt),
    .ifid_usert     (s.ifid_usert),
    .idex_wsel_l    (s.idex_wsel_l),
    .idex_regen_l   (s.idex_regen_l),
    .idex_dmemREN_l (s.idex_dmemREN_l),
    .idex_rsel1_l   (s.idex_rsel1_l),
    .idex_rsel2_l   (s.idex_rsel2_l),
    .exmem_wsel     (s.exmem_wsel),
    .exmem_regen    (s.exmem_regen),
    .exmem_dmemREN  (s.exmem_dmemREN),
    .exmem_dmemWEN  (s.exmem_dmemWEN),
    .memwb_wsel     (s.memwb_wsel),
    .memwb_regen    (s.memwb_regen),
    .memwb_hlt      (s.memwb_hlt),
    .br_taken       (s.br_taken),
    .pc_en          (pc_en),
    .ifid_en        (ifid_en),
    .idex_en        (idex_en),
    .exmem_en       (exmem_en),
    .memwb_en       (memwb_en),
    .ifid_sRST      (ifid_sRST),
    .idex_sRST      (idex_sRST),
    .exmem_sRST     (exmem_sRST),
    .memwb_sRST     (memwb_sRST),
    .fwdA           (fwdA),
    .fwdB           (fwdB),
    .halt           (halt),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
  );

  function automatic stim_t idle();
    stim_t x = '0;
    x.ihit = 1'b1;
    x.dhit = 1'b1;
    return x;
  endfunction

  function automatic stim_t rand_stim();
    stim_t x;
    x.ihit           = ($urandom_range(0, 7) != 0);
    x.dhit           = ($urandom_range(0, 3) != 0);
    x.ifid_rs        = 5'($urandom_range(0, 3));
    x.ifid_rt        = 5'($urandom_range(0, 3));
    x.ifid_usert     = 1'($urandom_range(0, 1));
    x.idex_wsel_l    = 5'($urandom_range(0, 3));
    x.idex_regen_l   = 1'($urandom_range(0, 1));
    x.idex_dmemREN_l = 1'($urandom_range(0, 1));
    x.idex_rsel1_l   = 5'($urandom_range(0, 3));
    x.idex_rsel2_l   = 5'($urandom_range(0, 3));
    x.exmem_wsel     = 5'($urandom_range(0, 3));
    x.exmem_regen    = 1'($urandom_range(0, 1));
    x.exmem_dmemREN  = ($urandom_range(0, 3) == 0);
    x.exmem_dmemWEN  = ($urandom_range(0, 5) == 0);
    x.memwb_wsel     = 5'($urandom_range(0, 3));
    x.memwb_regen    = 1'($urandom_range(0, 1));
    x.memwb_hlt      = ($urandom_range(0, 39) == 0);
    x.br_taken       = ($urandom_range(0, 7) == 0);
    return x;
  endfunction

  // Reference model: which of the prioritized pipeline actions applies this cycle.
  function automatic bit dep(stim_t x, logic [4:0] r);
    return (r != 0) && ((r == x.ifid_rs) || (x.ifid_usert && (r == x.ifid_rt)));
  endfunction

  function automatic bit m_haz(stim_t x);
    bit h = x.idex_dmemREN_l && x.idex_regen_l && dep(x, x.idex_wsel_l);
    if (!FWD && x.idex_regen_l && dep(x, x.idex_wsel_l)) h = 1'b1;
    if (!FWD && x.exmem_regen && dep(x, x.exmem_wsel)) h = 1'b1;
    return h;
  endfunction

  function automatic int m_case(stim_t x);
    if (!m_run) return 0;
    if (m_halted) return 1;
    if ((x.exmem_dmemREN || x.exmem_dmemWEN) && !x.dhit) return 2;
    if (x.br_taken) return 3;
    if (m_haz(x)) return 4;
    if (!x.ihit) return 5;
    return 6;
  endfunction

  // {pc, en ifid/idex/exmem/memwb, sRST ifid/idex/exmem/memwb}
  function automatic logic [8:0] m_ctrl(int c);
    case (c)
      2:       return 9'b0_0000_0001;
      3:       return 9'b1_0001_1110;
      4:       return 9'b0_0011_0100;
      5:       return 9'b0_0111_1000;
      6:       return 9'b1_1111_0000;
      default: return 9'b0_0000_0000;
    endcase
  endfunction

  function automatic logic [1:0] m_fwd(stim_t x, logic [4:0] r);
    logic [1:0] f = 2'b00;
    if (x.memwb_regen && (x.memwb_wsel != 0) && (x.memwb_wsel == r)) f = 2'b10;
    if (x.exmem_regen && (x.exmem_wsel != 0) && (x.exmem_wsel == r)) f = 2'b01;
    return (FWD && m_run) ? f : 2'b00;
  endfunction

  function automatic logic [13:0] predict();
    int c = m_case(s);
    return {m_ctrl(c), m_fwd(s, s.idex_rsel1_l), m_fwd(s, s.idex_rsel2_l), 1'(c == 1)};
  endfunction

  function automatic logic [13:0] observe();
    return {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
            ifid_sRST, idex_sRST, exmem_sRST, memwb_sRST, fwdA, fwdB, halt};
  endfunction

  task automatic m_commit();
    int c = m_case(s);
    logic [8:0] k = m_ctrl(c);
    if ((c inside {2, 4, 5}) && (m_stall < SAT)) m_stall++;
    if ((c == 3) && (m_flush < SAT)) m_flush++;
    if (k[4] && s.memwb_hlt) m_halted = 1'b1;
    if (nRST) m_run = 1'b1;
  endtask

  task automatic m_clear();
    m_run = 1'b0;
    m_halted = 1'b0;
    m_stall = 0;
    m_flush = 0;
  endtask

  task automatic tick();
    @(posedge CLK);
    m_commit();
    @(negedge CLK);
  endtask

  task automatic start();
    @(negedge CLK);
    s = idle();
    nRST = 1'b0;
    m_clear();
    @(negedge CLK);
    nRST = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    s = idle();
    nRST = 1'b0;
    m_clear();
    #1;
    tests_run++;
    if (observe() !== 14'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got %b expected %b", observe(), 14'd0);
    end
    @(posedge CLK);
    #1;
    tests_run++;
    if ({observe(), stall_cnt, flush_cnt} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_clocked: got %b/%0d/%0d expected all 0", observe(), stall_cnt, flush_cnt);
    end
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    tests_run++;
    if ({pc_en, ifid_en, idex_en, exmem_en, memwb_en} !== 5'b00000) begin
      tests_failed++;
      $display("[TB] FAIL first_cycle_en: got %b expected 00000", {pc_en, ifid_en, idex_en, exmem_en, memwb_en});
    end
    tick();
    #1;
    tests_run++;
    if (observe() !== predict() || {pc_en, ifid_en, idex_en, exmem_en, memwb_en} !== 5'b11111) begin
      tests_failed++;
      $display("[TB] FAIL running_en: got %b expected %b", observe(), predict());
    end
    tick();
    #1;
    tests_run++;
    if (stall_cnt !== 0 || flush_cnt !== 0) begin
      tests_failed++;
      $display("[TB] FAIL idle_counters: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_load_use();
    start();
    s.idex_dmemREN_l = 1'b1;
    s.idex_regen_l   = 1'b1;
    s.idex_wsel_l    = 5'd3;
    s.ifid_rs        = 5'd3;
    #1;
    tests_run++;
    if (observe() !== predict() || {pc_en, ifid_en, idex_sRST, exmem_en, memwb_en} !== 5'b00111) begin
      tests_failed++;
      $display("[TB] FAIL load_use_ctrl: got %b expected %b", observe(), predict());
    end
    tick();
    s = idle();
    #1;
    tests_run++;
    if (stall_cnt !== 4'd1) begin
      tests_failed++;
      $display("[TB] FAIL load_use_count: got %0d expected 1", stall_cnt);
    end
    s.idex_dmemREN_l = 1'b1;
    s.idex_regen_l   = 1'b1;
    s.idex_wsel_l    = 5'd0;
    s.ifid_rs        = 5'd0;
    #1;
    tests_run++;
    if (observe() !== predict() || pc_en !== 1'b1 || idex_sRST !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL load_use_r0: got %b expected %b", observe(), predict());
    end
    tick();
  endtask

  task automatic test_dcache_miss();
    start();
    s.exmem_dmemREN = 1'b1;
    s.dhit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests_run++;
      if (observe() !== predict() || memwb_sRST !== 1'b1 || pc_en !== 1'b0 || exmem_en !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL dmiss_frozen[%0d]: got %b expected %b", i, observe(), predict());
      end
      tick();
    end
    s.dhit = 1'b1;
    #1;
    tests_run++;
    if ({pc_en, ifid_en, idex_en, exmem_en, memwb_en, memwb_sRST} !== 6'b111110) begin
      tests_failed++;
      $display("[TB] FAIL dmiss_release: got %b expected 111110", {pc_en, ifid_en, idex_en, exmem_en, memwb_en, memwb_sRST});
    end
    tests_run++;
    if (stall_cnt !== 4'd4) begin
      tests_failed++;
      $display("[TB] FAIL dmiss_count: got %0d expected 4", stall_cnt);
    end
    tick();
  endtask

  task automatic test_branch_vs_haz();
    start();
    s.idex_dmemREN_l = 1'b1;
    s.idex_regen_l   = 1'b1;
    s.idex_wsel_l    = 5'd7;
    s.ifid_rt        = 5'd7;
    s.ifid_usert     = 1'b1;
    s.br_taken       = 1'b1;
    #1;
    tests_run++;
    if (observe() !== predict() ||
        {pc_en, ifid_sRST, idex_sRST, exmem_sRST, memwb_en, ifid_en, memwb_sRST} !== 7'b1111100) begin
      tests_failed++;
      $display("[TB] FAIL branch_wins: got %b expected %b", observe(), predict());
    end
    tick();
    s = idle();
    #1;
    tests_run++;
    if (flush_cnt !== 4'd1 || stall_cnt !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL branch_count: got flush %0d stall %0d expected 1/0", flush_cnt, stall_cnt);
    end
    tick();
  endtask

  task automatic test_forwarding();
    start();
    s.exmem_regen  = 1'b1;
    s.exmem_wsel   = 5'd5;
    s.memwb_regen  = 1'b1;
    s.memwb_wsel   = 5'd5;
    s.idex_rsel1_l = 5'd5;
    s.ifid_rs      = 5'd5;
    #1;
    tests_run++;
    if (observe() !== predict() || fwdA !== (FWD ? 2'b01 : 2'b00) || idex_sRST !== !FWD) begin
      tests_failed++;
      $display("[TB] FAIL fwd_exmem_first: got %b expected %b", observe(), predict());
    end
    s.exmem_regen  = 1'b0;
    s.idex_rsel2_l = 5'd5;
    s.idex_rsel1_l = 5'd9;
    #1;
    tests_run++;
    if (observe() !== predict() || fwdB !== (FWD ? 2'b10 : 2'b00) || fwdA !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL fwd_memwb: got %b expected %b", observe(), predict());
    end
    tick();
    s = idle();
  endtask

  task automatic test_halt();
    int st, fl;
    start();
    s.memwb_hlt = 1'b1;
    s.exmem_dmemREN = 1'b1;
    s.dhit = 1'b0;
    #1;
    tests_run++;
    if (observe() !== predict()) begin
      tests_failed++;
      $display("[TB] FAIL halt_miss_ctrl: got %b expected %b", observe(), predict());
    end
    tick();
    #1;
    tests_run++;
    if (halt !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL halt_waits_miss: got %b expected 0", halt);
    end
    s.dhit = 1'b1;
    tick();
    s = idle();
    s.ihit = 1'b0;
    s.br_taken = 1'b1;
    st = m_stall;
    fl = m_flush;
    #1;
    tests_run++;
    if (halt !== 1'b1 || {pc_en, ifid_en, idex_en, exmem_en, memwb_en} !== 5'b00000) begin
      tests_failed++;
      $display("[TB] FAIL halt_entry: got %b expected halt with en 0", observe());
    end
    repeat (3) tick();
    #1;
    tests_run++;
    if (stall_cnt !== st[CW-1:0] || flush_cnt !== fl[CW-1:0] || halt !== 1'b1 || observe() !== predict()) begin
      tests_failed++;
      $display("[TB] FAIL halt_frozen: got %0d/%0d halt %b expected %0d/%0d halt 1", stall_cnt, flush_cnt, halt, st, fl);
    end
    #2;
    nRST = 1'b0;
    m_clear();
    #1;
    tests_run++;
    if ({observe(), stall_cnt, flush_cnt} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL halt_async_reset: got %b/%0d/%0d expected all 0", observe(), stall_cnt, flush_cnt);
    end
    @(negedge CLK);
    nRST = 1'b1;
    s = idle();
    tick();
  endtask

  task automatic test_saturation();
    start();
    s.ihit = 1'b0;
    repeat (SAT + 3) tick();
    #1;
    tests_run++;
    if (stall_cnt !== 4'hF || stall_cnt !== m_stall[CW-1:0]) begin
      tests_failed++;
      $display("[TB] FAIL stall_saturate: got %0d expected 15", stall_cnt);
    end
    s.br_taken = 1'b1;
    repeat (SAT + 2) tick();
    #1;
    tests_run++;
    if (flush_cnt !== 4'hF || stall_cnt !== 4'hF) begin
      tests_failed++;
      $display("[TB] FAIL flush_saturate: got %0d/%0d expected 15/15", flush_cnt, stall_cnt);
    end
    s = idle();
  endtask

  task automatic test_random();
    start();
    for (int i = 0; i < 400; i++) begin
      s = rand_stim();
      #1;
      tests_run++;
      if (observe() !== predict() || {stall_cnt, flush_cnt} !== {m_stall[CW-1:0], m_flush[CW-1:0]}) begin
        tests_failed++;
        $display("[TB] FAIL random[%0d]: got %b cnt %0d/%0d expected %b cnt %0d/%0d",
                 i, observe(), stall_cnt, flush_cnt, predict(), m_stall, m_flush);
      end
      tick();
      if (m_halted && ($urandom_range(0, 3) == 0)) start();
    end
  endtask

  initial begin
    s = idle();
    test_reset();
    test_load_use();
    test_dcache_miss();
    test_branch_vs_haz();
    test_forwarding();
    test_halt();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "[TB] time limit");
  end

endmodule
